// File: rtl/dmem_ctrl_if.sv
// Memory bus between the data-memory controller (master) and the memory (slave).
interface dmem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns datapath load/store requests into a req/ack bus
// transaction, stalling the pipeline and aborting with a fault on misalignment or timeout.
module dmem_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        fault,
  output logic [31:0] stall_cnt,
  dmem_ctrl_if.master bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [DW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   wdata_q,     wdata_d;
  logic            we_q,        we_d;
  logic [WW-1:0]   wait_q,      wait_d;
  logic            fault_q,     fault_d;
  logic [DW-1:0]   readdata_q,  readdata_d;
  logic [DW-1:0]   stall_cnt_q, stall_cnt_d;

  logic access;
  logic misaligned;
  logic stall_c;
  logic fault_c;

  assign access     = memread | memwrite;
  assign misaligned = (addr[1:0] != 2'b00);

  // Next-state, latch and combinational handshake outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    readdata_d = readdata_q;
    stall_c    = 1'b0;
    fault_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            fault_c    = 1'b1;
            readdata_d = '0;
          end else begin
            stall_c = 1'b1;
            addr_d  = addr;
            wdata_d = wdata;
            we_d    = memwrite;
            wait_d  = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        // An ack always wins over a timeout falling on the same cycle
        if (bus.mem_ack) begin
          if (!we_q) readdata_d = bus.mem_rdata;
          wait_d  = '0;
          state_d = DONE;
        end else if (wait_q == TIMEOUT) begin
          readdata_d = '0;
          fault_d    = 1'b1;
          wait_d     = '0;
          state_d    = DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      DONE: begin
        fault_c = fault_q;
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must silence the combinational stall/fault paths immediately
  assign stall = stall_c & ~rst;
  assign fault = fault_c & ~rst;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wait_q      <= '0;
      fault_q     <= 1'b0;
      readdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      fault_q     <= fault_d;
      readdata_q  <= readdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign readdata      = readdata_q;
  assign stall_cnt     = stall_cnt_q;
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized accesses
// against a transaction-level model of stall count, readdata and fault.
module tb_dmem_ctrl;

  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread, memwrite;
  logic [31:0] addr, wdata;
  logic [31:0] readdata;
  logic        stall, fault;
  logic [31:0] stall_cnt;

  dmem_ctrl_if bus_if ();

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .readdata  (readdata),
    .stall     (stall),
    .fault     (fault),
    .stall_cnt (stall_cnt),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp_rd;
  logic [31:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int unsigned b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic idle_cycle();
    memread  = 1'b0;
    memwrite = 1'b0;
    bus_if.mem_ack   = 1'($urandom_range(0, 1));
    bus_if.mem_rdata = $urandom;
    #1;
    check("idle_stall", stall, 0);
    check("idle_fault", fault, 0);
    check("idle_req", bus_if.mem_req, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One access; ack_n = BUSY cycle (1-based) carrying mem_ack, 0 = never acked.
  // Starts and ends just after a negedge with the controller in IDLE.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int ack_n);
    bit mis;
    bit acked;
    int busy;
    mis   = (a[1:0] != 2'b00);
    acked = (ack_n != 0) && (ack_n <= int'(TO) + 1);
    busy  = acked ? ack_n : int'(TO) + 1;

    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = wd;
    #1;
    if (mis) begin
      check("mis_fault", fault, 1);
      check("mis_stall", stall, 0);
      check("mis_req", bus_if.mem_req, 0);
      @(posedge clk);
      @(negedge clk);
      memread  = 1'b0;
      memwrite = 1'b0;
      exp_rd   = 32'h0;
      #1;
      check("mis_rdata", readdata, exp_rd);
      check("mis_req2", bus_if.mem_req, 0);
      check("mis_cnt", stall_cnt, exp_cnt);
      return;
    end

    check("idle_stall_hi", stall, 1);
    check("idle_fault_lo", fault, 0);
    check("idle_req_lo", bus_if.mem_req, 0);
    @(posedge clk);
    for (int k = 1; k <= busy; k++) begin
      @(negedge clk);
      check("busy_req", bus_if.mem_req, 1);
      check("busy_stall", stall, 1);
      check("busy_fault", fault, 0);
      check("busy_we", bus_if.mem_we, 32'(wr));
      check("busy_addr", bus_if.mem_addr, a);
      check("busy_wdata", bus_if.mem_wdata, wd);
      check("busy_rdata_hold", readdata, exp_rd);
      bus_if.mem_ack   = (k == ack_n);
      bus_if.mem_rdata = (k == ack_n) ? rdat : $urandom;
      @(posedge clk);
    end

    @(negedge clk);
    bus_if.mem_ack   = 1'($urandom_range(0, 1));
    bus_if.mem_rdata = $urandom;
    if (!acked)  exp_rd = 32'h0;
    else if (!wr) exp_rd = rdat;
    exp_cnt = sat_add(exp_cnt, busy + 1);
    #1;
    check("done_stall", stall, 0);
    check("done_req", bus_if.mem_req, 0);
    check("done_fault", fault, 32'(!acked));
    check("done_rdata", readdata, exp_rd);
    check("done_cnt", stall_cnt, exp_cnt);
    @(posedge clk);
    @(negedge clk);
    memread  = 1'b0;
    memwrite = 1'b0;
    bus_if.mem_ack = 1'b0;
    #1;
    check("post_stall", stall, 0);
    check("post_fault", fault, 0);
    check("post_req", bus_if.mem_req, 0);
    check("post_rdata", readdata, exp_rd);
  endtask

  initial begin
    rst = 1'b1;
    memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = '0;
    exp_rd = '0; exp_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", readdata, 0);
    check("rst_stall", stall, 0);
    check("rst_fault", fault, 0);
    check("rst_req", bus_if.mem_req, 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_we", bus_if.mem_we, 0);
    check("rst_addr", bus_if.mem_addr, 0);
    rst = 1'b0;
    idle_cycle();

    access(1, 0, 32'h10, 32'h0, 32'hCAFE_0001, 1);
    check("ld_cnt2", stall_cnt, 2);
    access(0, 1, 32'h20, 32'h1234_5678, 32'h5555_AAAA, 3);
    access(1, 0, 32'h13, 32'h0, 32'h0, 1);
    access(1, 0, 32'h30, 32'h0, 32'h7777_7777, 0);
    access(1, 0, 32'h34, 32'h0, 32'hA5A5_0005, 5);

    // Asynchronous reset in the 2nd BUSY cycle, with a late ack that must be ignored
    memread = 1'b1; addr = 32'h40;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    check("pre_rst_req", bus_if.mem_req, 1);
    #1 rst = 1'b1;
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("arst_req", bus_if.mem_req, 0);
    check("arst_stall", stall, 0);
    check("arst_rdata", readdata, 0);
    check("arst_cnt", stall_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    memread = 1'b0; rst = 1'b0; bus_if.mem_ack = 1'b0;
    exp_rd = '0; exp_cnt = '0;
    idle_cycle();
    access(1, 0, 32'h44, 32'h0, 32'h0BAD_F00D, 2);

    // Saturation of stall_cnt, with a combined read+write issuing a bus write
    dut.stall_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    #1;
    check("preset_cnt", stall_cnt, exp_cnt);
    access(1, 1, 32'h80, 32'hDEAD_BEEF, 32'h1111_2222, 1);
    access(1, 0, 32'h84, 32'h0, 32'h3333_4444, 2);

    for (int i = 0; i < 150; i++) begin
      int op;
      logic [31:0] ra;
      op = int'($urandom_range(0, 3));
      ra = $urandom;
      ra[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (op == 0) idle_cycle();
      else access(op[0], op[1], ra, $urandom, $urandom, int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
